branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
// Controls next-PC sequencing around the EX-stage jump unit. The IF stage gets a prediction from
// a direct-mapped branch target buffer (BTB) with 2-bit counters. Each prediction travels down
// the pipe to EX, where it is checked against the jump unit's resolved is_jump/taken_pc. On a
// mispredict the block issues the PC redirect and the IF_ID/ID_EX flushes, and it trains the BTB.
// PARAMETERS
// BTB_ENTRIES  16  entry count, power of 2 (index = pc[IDX_W+1:2], IDX_W = log2(BTB_ENTRIES))
// PC_W         32  PC/target width
// PORTS
// clk               in   1     clock
// reset             in   1     synchronous active-high reset
// IF_current_pc     in   PC_W  PC being fetched
// IF_pred_taken     out  1     BTB predicts taken for IF_current_pc
// IF_pred_pc        out  PC_W  predicted next PC (target if taken, else IF_current_pc+4)
// ID_EX_valid       in   1     EX holds a real instruction (0 = bubble)
// ex_hold           in   1     EX does not advance this cycle
// ID_EX_current_pc  in   PC_W  PC of EX instruction
// ID_EX_pred_taken  in   1     prediction carried with EX instruction
// ID_EX_pred_pc     in   PC_W  predicted next PC carried with EX instruction
// ID_EX_is_jal      in   1     EX is JAL
// ID_EX_is_jalr     in   1     EX is JALR
// ID_EX_branch      in   1     EX is conditional branch
// is_jump           in   1     jump unit: control transfer taken
// taken_pc          in   PC_W  jump unit: resolved target
// redirect          out  1     PC mux select: load redirect_pc
// redirect_pc       out  PC_W  corrected next PC
// flush_IF_ID       out  1     squash IF_ID at next edge
// flush_ID_EX       out  1     squash ID_EX at next edge
// ctrl_count        out  32    resolved control instructions
// mispredict_count  out  32    mispredicts
// BEHAVIOUR
// - Reset: every valid bit = 0, every counter = 2'b01 (weakly not-taken), both perf counters = 0.
//   Combinational outputs follow immediately; with an empty BTB, IF_pred_taken=0 and IF_pred_pc=PC+4.
// - Lookup (combinational, 0 latency): hit = valid[idx] && tag[idx]==IF_current_pc[PC_W-1:IDX_W+2].
//   - pred_taken = hit && (uncond[idx] || ctr[idx][1]).
//   - Target fetched from stored tgt[idx].
// - Resolve is active when ID_EX_valid && !ex_hold.
//   - ctrl = is_jal | is_jalr | branch.
//   - actual = is_jump ? taken_pc : ID_EX_current_pc+4.
//   - mispredict = (ID_EX_pred_taken != is_jump) || (is_jump && ID_EX_pred_pc != taken_pc).
//   - Non-ctrl instr with pred_taken=1 (BTB alias) is also a mispredict; actual = PC+4.
// - Redirect (combinational, same cycle as resolve): redirect = flush_IF_ID = flush_ID_EX = mispredict.
//   redirect_pc = actual. All three are 0 when resolve is inactive. redirect_pc = 0 when redirect = 0.
// - Training happens at the clock edge while resolve is active. i = EX-PC index.
//   - ctrl, hit, taken: counter increments, saturating at 3. tgt <= taken_pc (JALR retarget).
//   - ctrl, hit, not-taken: counter decrements, saturating at 0.
//   - ctrl, miss, taken: allocate: valid=1, tag, tgt=taken_pc, ctr=2'b10, uncond=is_jal|is_jalr.
//   - ctrl, miss, not-taken: no change.
//   - Non-ctrl with a stale hit: valid[i] <= 0.
// - Perf counters: ctrl_count += ctrl; mispredict_count += mispredict. Both wrap modulo 2^32.
// - Simultaneous IF lookup and EX update to the same index: lookup returns the pre-edge
//   contents (no bypass). The new value is visible from the next cycle.
// - ex_hold=1 or bubble: no redirect, no training, no count, so a held instruction is not
//   double-trained.
// - Reset asserted mid-operation wins over training at that edge. Redirect is gated off while reset=1.
// - PC arithmetic is modulo 2^PC_W. PC+4 wraps from 0xFFFFFFFC to 0.
// STRUCTURE
// - Shared package: counter encodings SNT=0/WNT=1/WT=2/ST=3, CTR_RESET=WNT, CTR_ALLOC=WT,
//   IDX_W/TAG_W derivation.
// - Sub-module btb_table: valid/tag/tgt/ctr/uncond arrays with 1 async read port (IF) and
//   1 sync write port (EX), plus a read of the EX index for hit detection.
//   Mispredict logic, redirect generation and perf counters stay in the top module.
// TESTING
// 1. Reset, then IF_current_pc=0x100 -> IF_pred_taken=0, IF_pred_pc=0x104; both counts 0.
// 2. BEQ at 0x200, pred not-taken, is_jump=1, taken_pc=0x240 -> redirect=1 and both flushes=1,
//    redirect_pc=0x240. Next cycle lookup of 0x200 gives pred_taken=1, IF_pred_pc=0x240;
//    mispredict_count=1.
// 3. Same branch resolves not-taken twice -> first: redirect_pc=0x204, ctr=1;
//    second: pred not-taken, no redirect, ctr=0 (saturated).
// 4. JALR at 0x300 trained to 0x400, then resolves to 0x480 -> redirect_pc=0x480, tgt updated.
//    Next lookup gives 0x480, ctr stays 3 at saturation.
// 5. Pred_taken=1 on non-ctrl instr at 0x500 -> redirect_pc=0x504; entry invalidated, next lookup misses.
// 6. ex_hold=1 during a mispredicting resolve -> no redirect, no counts. Released next cycle ->
//    exactly one redirect and mispredict_count += 1. Reset asserted the same cycle as an update
//    -> all BTB entries invalid.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared sizing, 2-bit counter encodings and the BTB entry layout for the
// branch redirect controller.
package branch_redirect_ctrl_pkg;

    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W       = PC_W - IDX_W - 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    localparam ctr_e CTR_RESET = CTR_WNT;
    localparam ctr_e CTR_ALLOC = CTR_WT;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  tgt;
        ctr_e             ctr;
        logic             uncond;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RESET = '{
        valid:  1'b0,
        tag:    '0,
        tgt:    '0,
        ctr:    CTR_RESET,
        uncond: 1'b0
    };

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        logic [1:0] v;
        v = c;
        if (taken) begin
            return (c == CTR_ST) ? CTR_ST : ctr_e'(v + 2'd1);
        end
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(v - 2'd1);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_btb_table.sv
// Direct-mapped BTB storage: async IF read, async EX read, one sync write at
// the EX index. Reads return pre-edge contents (no write bypass).
module branch_redirect_ctrl_btb_table
    import branch_redirect_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output btb_entry_t       o_rd_entry,
    input  logic [IDX_W-1:0] i_ex_idx,
    output btb_entry_t       o_ex_entry,
    input  logic             i_wr_en,
    input  btb_entry_t       i_wr_entry
);

    btb_entry_t r_mem [BTB_ENTRIES];

    assign o_rd_entry = r_mem[i_rd_idx];
    assign o_ex_entry = r_mem[i_ex_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                r_mem[i] <= ENTRY_RESET;
            end
        end else if (i_wr_en) begin
            r_mem[i_ex_idx] <= i_wr_entry;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Next-PC prediction from the BTB, EX-stage mispredict detection with
// redirect/flush generation, BTB training and performance counters.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   IF_current_pc,
    output logic              IF_pred_taken,
    output logic [PC_W-1:0]   IF_pred_pc,
    input  logic              ID_EX_valid,
    input  logic              ex_hold,
    input  logic [PC_W-1:0]   ID_EX_current_pc,
    input  logic              ID_EX_pred_taken,
    input  logic [PC_W-1:0]   ID_EX_pred_pc,
    input  logic              ID_EX_is_jal,
    input  logic              ID_EX_is_jalr,
    input  logic              ID_EX_branch,
    input  logic              is_jump,
    input  logic [PC_W-1:0]   taken_pc,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush_IF_ID,
    output logic              flush_ID_EX,
    output logic [CNT_W-1:0]  ctrl_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    btb_entry_t       w_if_entry;
    btb_entry_t       w_ex_entry;
    btb_entry_t       w_wr_entry;
    logic             w_wr_en;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_resolve;
    logic             w_ctrl;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_redirect;
    logic [PC_W-1:0]  w_actual;
    logic [CNT_W-1:0] r_ctrl_count;
    logic [CNT_W-1:0] r_mispredict_count;

    assign w_if_idx = IF_current_pc[IDX_W+1:2];
    assign w_ex_idx = ID_EX_current_pc[IDX_W+1:2];

    branch_redirect_ctrl_btb_table u_btb (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_if_idx),
        .o_rd_entry (w_if_entry),
        .i_ex_idx   (w_ex_idx),
        .o_ex_entry (w_ex_entry),
        .i_wr_en    (w_wr_en),
        .i_wr_entry (w_wr_entry)
    );

    // IF lookup
    assign w_if_hit      = w_if_entry.valid && (w_if_entry.tag == IF_current_pc[PC_W-1:IDX_W+2]);
    assign IF_pred_taken = w_if_hit && (w_if_entry.uncond || w_if_entry.ctr[1]);
    assign IF_pred_pc    = IF_pred_taken ? w_if_entry.tgt : IF_current_pc + PC_W'(4);

    // EX resolve; a non-control instruction never counts as taken
    assign w_ex_hit     = w_ex_entry.valid && (w_ex_entry.tag == ID_EX_current_pc[PC_W-1:IDX_W+2]);
    assign w_resolve    = ID_EX_valid && !ex_hold && !reset;
    assign w_ctrl       = ID_EX_is_jal || ID_EX_is_jalr || ID_EX_branch;
    assign w_taken      = w_ctrl && is_jump;
    assign w_actual     = w_taken ? taken_pc : ID_EX_current_pc + PC_W'(4);
    assign w_mispredict = (ID_EX_pred_taken != w_taken) || (w_taken && (ID_EX_pred_pc != taken_pc));
    assign w_redirect   = w_resolve && w_mispredict;

    assign redirect    = w_redirect;
    assign flush_IF_ID = w_redirect;
    assign flush_ID_EX = w_redirect;
    assign redirect_pc = w_redirect ? w_actual : '0;

    // BTB training at the EX index
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_ex_entry;
        if (w_resolve) begin
            if (w_ctrl) begin
                if (w_ex_hit) begin
                    w_wr_en        = 1'b1;
                    w_wr_entry.ctr = ctr_next(w_ex_entry.ctr, w_taken);
                    if (w_taken) begin
                        w_wr_entry.tgt = taken_pc;
                    end
                end else if (w_taken) begin
                    w_wr_en    = 1'b1;
                    w_wr_entry = '{
                        valid:  1'b1,
                        tag:    ID_EX_current_pc[PC_W-1:IDX_W+2],
                        tgt:    taken_pc,
                        ctr:    CTR_ALLOC,
                        uncond: ID_EX_is_jal || ID_EX_is_jalr
                    };
                end
            end else if (w_ex_hit) begin
                w_wr_en          = 1'b1;
                w_wr_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_count       <= '0;
            r_mispredict_count <= '0;
        end else if (w_resolve) begin
            r_ctrl_count       <= r_ctrl_count + CNT_W'(w_ctrl);
            r_mispredict_count <= r_mispredict_count + CNT_W'(w_mispredict);
        end
    end

    assign ctrl_count       = r_ctrl_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed plus randomized check of branch_redirect_ctrl against a BTB
// reference model held as plain per-index arrays.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_current_pc;
    logic        IF_pred_taken;
    logic [31:0] IF_pred_pc;
    logic        ID_EX_valid;
    logic        ex_hold;
    logic [31:0] ID_EX_current_pc;
    logic        ID_EX_pred_taken;
    logic [31:0] ID_EX_pred_pc;
    logic        ID_EX_is_jal;
    logic        ID_EX_is_jalr;
    logic        ID_EX_branch;
    logic        is_jump;
    logic [31:0] taken_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic [31:0] ctrl_count;
    logic [31:0] mispredict_count;

    branch_redirect_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .IF_current_pc    (IF_current_pc),
        .IF_pred_taken    (IF_pred_taken),
        .IF_pred_pc       (IF_pred_pc),
        .ID_EX_valid      (ID_EX_valid),
        .ex_hold          (ex_hold),
        .ID_EX_current_pc (ID_EX_current_pc),
        .ID_EX_pred_taken (ID_EX_pred_taken),
        .ID_EX_pred_pc    (ID_EX_pred_pc),
        .ID_EX_is_jal     (ID_EX_is_jal),
        .ID_EX_is_jalr    (ID_EX_is_jalr),
        .ID_EX_branch     (ID_EX_branch),
        .is_jump          (is_jump),
        .taken_pc         (taken_pc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush_IF_ID      (flush_IF_ID),
        .flush_ID_EX      (flush_ID_EX),
        .ctrl_count       (ctrl_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // reference model: one slot per index, tag = pc / 64, counter as int 0..3
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_unc   [16];
    logic [31:0] m_cc;
    logic [31:0] m_mc;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_unc[idx_of(pc)] || m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
            m_unc[i]   = 1'b0;
        end
        m_cc = '0;
        m_mc = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check combinational outputs and counters, advance model, clock.
    task automatic step(input bit rst, input logic [31:0] ifpc, input bit v, input bit hold,
                        input logic [31:0] expc, input bit pt, input logic [31:0] ppc,
                        input bit jal, input bit jalr, input bit br, input bit jmp,
                        input logic [31:0] tpc, input string tag);
        bit          res, ctrl, tk, mis, red;
        logic [31:0] act;
        int unsigned i;
        reset = rst; IF_current_pc = ifpc; ID_EX_valid = v; ex_hold = hold;
        ID_EX_current_pc = expc; ID_EX_pred_taken = pt; ID_EX_pred_pc = ppc;
        ID_EX_is_jal = jal; ID_EX_is_jalr = jalr; ID_EX_branch = br;
        is_jump = jmp; taken_pc = tpc;
        #2;
        res  = v && !hold && !rst;
        ctrl = jal || jalr || br;
        tk   = ctrl && jmp;
        act  = tk ? tpc : expc + 32'd4;
        mis  = (pt != tk) || (tk && ppc != tpc);
        red  = res && mis;
        chk($sformatf("%s.pred_taken", tag), 32'(IF_pred_taken), 32'(m_pred(ifpc)));
        chk($sformatf("%s.pred_pc", tag), IF_pred_pc, m_pred_pc(ifpc));
        chk($sformatf("%s.redirect", tag), 32'(redirect), 32'(red));
        chk($sformatf("%s.redirect_pc", tag), redirect_pc, red ? act : 32'd0);
        chk($sformatf("%s.flush_if_id", tag), 32'(flush_IF_ID), 32'(red));
        chk($sformatf("%s.flush_id_ex", tag), 32'(flush_ID_EX), 32'(red));
        chk($sformatf("%s.ctrl_count", tag), ctrl_count, m_cc);
        chk($sformatf("%s.mispredict_count", tag), mispredict_count, m_mc);
        if (rst) begin
            m_clear();
        end else if (res) begin
            i = idx_of(expc);
            if (ctrl) begin
                if (m_hit(expc)) begin
                    if (tk) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = tpc;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (tk) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(expc);
                    m_tgt[i]   = tpc;
                    m_ctr[i]   = 2;
                    m_unc[i]   = jal || jalr;
                end
            end else if (m_hit(expc)) begin
                m_valid[i] = 1'b0;
            end
            m_cc = m_cc + 32'(ctrl);
            m_mc = m_mc + 32'(mis);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 | 32'($urandom_range(0, 3) << 6) | 32'($urandom_range(0, 7) << 2);
    endfunction

    initial begin
        logic [31:0] r_ex, r_if, r_ppc;
        bit          r_pt, r_jmp, r_jal, r_jalr, r_br;
        int          kind;

        m_clear();
        reset = 1'b1; IF_current_pc = '0; ID_EX_valid = 1'b0; ex_hold = 1'b0;
        ID_EX_current_pc = '0; ID_EX_pred_taken = 1'b0; ID_EX_pred_pc = '0;
        ID_EX_is_jal = 1'b0; ID_EX_is_jalr = 1'b0; ID_EX_branch = 1'b0;
        is_jump = 1'b0; taken_pc = '0;
        repeat (2) @(posedge clk);
        #1;

        // empty BTB after reset
        step(0, 32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "reset_lookup");
        // BEQ at 0x200 taken while predicted not-taken
        step(0, 32'h200, 1, 0, 32'h200, 0, 32'h204, 0, 0, 1, 1, 32'h240, "beq_taken");
        step(0, 32'h200, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "beq_lookup");
        // same branch resolves not-taken twice
        step(0, 32'h200, 1, 0, 32'h200, 1, 32'h240, 0, 0, 1, 0, 32'h0, "beq_nt1");
        step(0, 32'h200, 1, 0, 32'h200, 0, 32'h204, 0, 0, 1, 0, 32'h0, "beq_nt2");
        step(0, 32'h200, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "beq_sat");
        // JALR at 0x300: allocate to 0x400, strengthen, then retarget to 0x480
        step(0, 32'h300, 1, 0, 32'h300, 0, 32'h304, 0, 1, 0, 1, 32'h400, "jalr_alloc");
        step(0, 32'h300, 1, 0, 32'h300, 1, 32'h400, 0, 1, 0, 1, 32'h400, "jalr_hit");
        step(0, 32'h300, 1, 0, 32'h300, 1, 32'h400, 0, 1, 0, 1, 32'h480, "jalr_retgt");
        step(0, 32'h300, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "jalr_lookup");
        // alias: non-ctrl at 0x500 with a stale hit
        step(0, 32'h500, 1, 0, 32'h500, 0, 32'h504, 0, 0, 1, 1, 32'h600, "alias_alloc");
        step(0, 32'h500, 1, 0, 32'h500, 1, 32'h600, 0, 0, 0, 0, 32'h0, "alias_nonctrl");
        step(0, 32'h500, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "alias_miss");
        // held mispredict, then released
        step(0, 32'h700, 1, 1, 32'h700, 0, 32'h704, 1, 0, 0, 1, 32'h800, "hold");
        step(0, 32'h700, 1, 0, 32'h700, 0, 32'h704, 1, 0, 0, 1, 32'h800, "release");
        step(0, 32'h700, 1, 0, 32'h700, 1, 32'h800, 1, 0, 0, 1, 32'h800, "jal_hit");
        // bubble never redirects
        step(0, 32'h700, 0, 0, 32'h900, 1, 32'h0, 0, 0, 1, 0, 32'h0, "bubble");
        // PC wrap
        step(0, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 1, 32'h0, 0, 0, 1, 0, 32'h0, "wrap_nt");
        step(0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "wrap_lookup");
        // reset concurrent with an update
        step(1, 32'h300, 1, 0, 32'h240, 0, 32'h244, 1, 0, 0, 1, 32'hA00, "reset_upd");
        step(0, 32'h300, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "post_rst_300");
        step(0, 32'h200, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "post_rst_200");
        step(0, 32'h240, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, "post_rst_240");

        // randomized traffic over a small PC pool so indices alias and tags collide
        for (int n = 0; n < 400; n++) begin
            r_ex = rnd_pc();
            r_if = ($urandom_range(0, 3) == 0) ? r_ex : rnd_pc();
            kind = $urandom_range(0, 3);
            r_jal  = (kind == 0);
            r_jalr = (kind == 1);
            r_br   = (kind == 2);
            r_jmp  = r_jal || r_jalr || (r_br && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) begin
                r_pt  = m_pred(r_ex);
                r_ppc = m_pred_pc(r_ex);
            end else begin
                r_pt  = 1'($urandom_range(0, 1));
                r_ppc = rnd_pc();
            end
            step(($urandom_range(0, 49) == 0), r_if, ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 5) == 0), r_ex, r_pt, r_ppc, r_jal, r_jalr, r_br,
                 r_jmp, rnd_pc(), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
